// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX boundary: writeback-source and opcode
// encodings, the registered control bundle, and operand-use helpers.
package id_ex_stage_pkg;

  localparam int unsigned IMM_SRC_W  = 3;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned WB_SRC_W   = 3;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT3_W   = 3;

  typedef enum logic [WB_SRC_W-1:0] {
    WB_SRC_ALU   = 3'b000,
    WB_SRC_MEM   = 3'b001,
    WB_SRC_PC4   = 3'b010,
    WB_SRC_IMM   = 3'b011,
    WB_SRC_AUIPC = 3'b100
  } wb_src_e;

  typedef enum logic [OPCODE_W-1:0] {
    OPCODE_LUI    = 7'b0110111,
    OPCODE_AUIPC  = 7'b0010111,
    OPCODE_JAL    = 7'b1101111,
    OPCODE_JALR   = 7'b1100111,
    OPCODE_BRANCH = 7'b1100011,
    OPCODE_LOAD   = 7'b0000011,
    OPCODE_STORE  = 7'b0100011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_OP     = 7'b0110011
  } opcode_e;

  // Field order is irrelevant to behaviour; an all-zero bundle is a bubble.
  typedef struct packed {
    logic                  alu_op_src;
    logic                  branch;
    logic                  jump;
    logic                  rf_we;
    logic                  bu_jb;
    logic                  mem_we;
    logic [IMM_SRC_W-1:0]  imm_src;
    logic [WB_SRC_W-1:0]   wb_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } ctrl_t;

  function automatic logic rs1_used(input logic [OPCODE_W-1:0] opcode);
    return !(opcode == OPCODE_LUI || opcode == OPCODE_AUIPC || opcode == OPCODE_JAL);
  endfunction

  function automatic logic rs2_used(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OPCODE_OP || opcode == OPCODE_STORE || opcode == OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in EX.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_rf_we,
  input  logic [WB_SRC_W-1:0]   ex_wb_src,
  input  logic                  ex_valid,
  output logic                  load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    ex_is_load = ex_valid && ex_rf_we && (ex_wb_src == WB_SRC_MEM) && (ex_rd_addr != '0);
    rs1_hit    = rs1_used(opcode) && (rs1_addr == ex_rd_addr);
    rs2_hit    = rs2_used(opcode) && (rs2_addr == ex_rd_addr);
    load_use   = ex_is_load && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional ID_EX_PERF_CNT_EN adds bubble/flush event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_op_src_ctrl,
  input  logic                  i_branch,
  input  logic                  i_jump,
  input  logic                  i_rf_we_ctrl,
  input  logic                  i_bu_jb_ctrl,
  input  logic                  i_mem_we,
  input  logic [IMM_SRC_W-1:0]  i_sx_imm_src_ctrl,
  input  logic [WB_SRC_W-1:0]   i_rf_wb_scr_ctrl,
  input  logic [ALU_CTRL_W-1:0] i_alu_ctrl,
  input  logic [OPCODE_W-1:0]   i_opcode,
  input  logic [FUNCT3_W-1:0]   i_funct3,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_pc_plus4,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [XLEN-1:0]       i_imm,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_id_valid,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic                  o_alu_op_src_ctrl,
  output logic                  o_branch,
  output logic                  o_jump,
  output logic                  o_rf_we_ctrl,
  output logic                  o_bu_jb_ctrl,
  output logic                  o_mem_we,
  output logic [IMM_SRC_W-1:0]  o_sx_imm_src_ctrl,
  output logic [WB_SRC_W-1:0]   o_rf_wb_scr_ctrl,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic [FUNCT3_W-1:0]   o_funct3,
  output logic [XLEN-1:0]       o_pc,
  output logic [XLEN-1:0]       o_pc_plus4,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  output logic [XLEN-1:0]       o_imm,
  output logic [REG_ADDR_W-1:0] o_rs1_addr,
  output logic [REG_ADDR_W-1:0] o_rs2_addr,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_valid,
  output logic                  o_hazard_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           o_bubble_cnt,
  output logic [31:0]           o_flush_cnt
`endif
);

  ctrl_t                 ctrl_d;
  ctrl_t                 ctrl_q;
  logic                  valid_q;
  logic [FUNCT3_W-1:0]   funct3_q;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       pc_plus4_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rs1_addr_q;
  logic [REG_ADDR_W-1:0] rs2_addr_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;

  logic load_use;
  logic clear;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .opcode     (i_opcode),
    .rs1_addr   (i_rs1_addr),
    .rs2_addr   (i_rs2_addr),
    .id_valid   (i_id_valid),
    .ex_rd_addr (rd_addr_q),
    .ex_rf_we   (ctrl_q.rf_we),
    .ex_wb_src  (ctrl_q.wb_src),
    .ex_valid   (valid_q),
    .load_use   (load_use)
  );

  always_comb begin
    ctrl_d.alu_op_src = i_alu_op_src_ctrl;
    ctrl_d.branch     = i_branch;
    ctrl_d.jump       = i_jump;
    ctrl_d.rf_we      = i_rf_we_ctrl;
    ctrl_d.bu_jb      = i_bu_jb_ctrl;
    ctrl_d.mem_we     = i_mem_we;
    ctrl_d.imm_src    = i_sx_imm_src_ctrl;
    ctrl_d.wb_src     = i_rf_wb_scr_ctrl;
    ctrl_d.alu_ctrl   = i_alu_ctrl;
  end

  // Reset, flush and a non-held load-use bubble all load the same all-zero state,
  // so they share one clear path; hold outranks only the load-use bubble.
  assign clear          = i_rst || i_flush || (!i_hold && load_use);
  assign o_hazard_stall = load_use && !i_flush && !i_hold;

  always_ff @(posedge i_clk) begin
    if (clear) begin
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      funct3_q   <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else if (!i_hold) begin
      ctrl_q     <= ctrl_d;
      valid_q    <= i_id_valid;
      funct3_q   <= i_funct3;
      pc_q       <= i_pc;
      pc_plus4_q <= i_pc_plus4;
      rs1_data_q <= i_rs1_data;
      rs2_data_q <= i_rs2_data;
      imm_q      <= i_imm;
      rs1_addr_q <= i_rs1_addr;
      rs2_addr_q <= i_rs2_addr;
      rd_addr_q  <= i_rd_addr;
    end
  end

  assign o_alu_op_src_ctrl = ctrl_q.alu_op_src;
  assign o_branch          = ctrl_q.branch;
  assign o_jump            = ctrl_q.jump;
  assign o_rf_we_ctrl      = ctrl_q.rf_we;
  assign o_bu_jb_ctrl      = ctrl_q.bu_jb;
  assign o_mem_we          = ctrl_q.mem_we;
  assign o_sx_imm_src_ctrl = ctrl_q.imm_src;
  assign o_rf_wb_scr_ctrl  = ctrl_q.wb_src;
  assign o_alu_ctrl        = ctrl_q.alu_ctrl;
  assign o_funct3          = funct3_q;
  assign o_pc              = pc_q;
  assign o_pc_plus4        = pc_plus4_q;
  assign o_rs1_data        = rs1_data_q;
  assign o_rs2_data        = rs2_data_q;
  assign o_imm             = imm_q;
  assign o_rs1_addr        = rs1_addr_q;
  assign o_rs2_addr        = rs2_addr_q;
  assign o_rd_addr         = rd_addr_q;
  assign o_valid           = valid_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;

  // Flushes count even under hold; load-use bubbles only when actually loaded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (i_flush) begin
      flush_cnt_q  <= flush_cnt_q + 32'd1;
    end else if (!i_hold && load_use) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (define ID_EX_PERF_CNT_EN to also
// exercise the event counters).
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_op_src, branch, jump, rf_we, bu_jb, mem_we;
  logic [2:0]      imm_src, wb_src;
  logic [3:0]      alu_ctrl;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc, pc_plus4, rs1_data, rs2_data, imm;
  logic [RAW-1:0]  rs1_addr, rs2_addr, rd_addr;
  logic            id_valid, flush, hold;

  logic            o_alu_op_src, o_branch, o_jump, o_rf_we, o_bu_jb, o_mem_we;
  logic [2:0]      o_imm_src, o_wb_src;
  logic [3:0]      o_alu_ctrl;
  logic [2:0]      o_funct3;
  logic [XLEN-1:0] o_pc, o_pc_plus4, o_rs1_data, o_rs2_data, o_imm;
  logic [RAW-1:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic            o_valid, o_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     o_bubble_cnt, o_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN       (XLEN),
    .REG_ADDR_W (RAW)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_alu_op_src_ctrl (alu_op_src),
    .i_branch          (branch),
    .i_jump            (jump),
    .i_rf_we_ctrl      (rf_we),
    .i_bu_jb_ctrl      (bu_jb),
    .i_mem_we          (mem_we),
    .i_sx_imm_src_ctrl (imm_src),
    .i_rf_wb_scr_ctrl  (wb_src),
    .i_alu_ctrl        (alu_ctrl),
    .i_opcode          (opcode),
    .i_funct3          (funct3),
    .i_pc              (pc),
    .i_pc_plus4        (pc_plus4),
    .i_rs1_data        (rs1_data),
    .i_rs2_data        (rs2_data),
    .i_imm             (imm),
    .i_rs1_addr        (rs1_addr),
    .i_rs2_addr        (rs2_addr),
    .i_rd_addr         (rd_addr),
    .i_id_valid        (id_valid),
    .i_flush           (flush),
    .i_hold            (hold),
    .o_alu_op_src_ctrl (o_alu_op_src),
    .o_branch          (o_branch),
    .o_jump            (o_jump),
    .o_rf_we_ctrl      (o_rf_we),
    .o_bu_jb_ctrl      (o_bu_jb),
    .o_mem_we          (o_mem_we),
    .o_sx_imm_src_ctrl (o_imm_src),
    .o_rf_wb_scr_ctrl  (o_wb_src),
    .o_alu_ctrl        (o_alu_ctrl),
    .o_funct3          (o_funct3),
    .o_pc              (o_pc),
    .o_pc_plus4        (o_pc_plus4),
    .o_rs1_data        (o_rs1_data),
    .o_rs2_data        (o_rs2_data),
    .o_imm             (o_imm),
    .o_rs1_addr        (o_rs1_addr),
    .o_rs2_addr        (o_rs2_addr),
    .o_rd_addr         (o_rd_addr),
    .o_valid           (o_valid),
    .o_hazard_stall    (o_stall)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .o_bubble_cnt      (o_bubble_cnt),
    .o_flush_cnt       (o_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoded instruction; data fields derive from pc so they are traceable.
  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic we, input logic [2:0] wb,
                       input logic [3:0] alu, input logic [31:0] p, input logic v);
    opcode   = op;
    rs1_addr = r1;
    rs2_addr = r2;
    rd_addr  = rd;
    rf_we    = we;
    wb_src   = wb;
    alu_ctrl = alu;
    pc       = p;
    pc_plus4 = p + 32'd4;
    rs1_data = p + 32'h1000;
    rs2_data = p + 32'h2000;
    imm      = p + 32'h3000;
    id_valid = v;
    alu_op_src = 1'b1;
    branch   = 1'b0;
    jump     = 1'b0;
    bu_jb    = 1'b0;
    mem_we   = 1'b0;
    imm_src  = 3'b001;
    funct3   = 3'b010;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    hold = 1'b0;
    drive(OP_OP, 5'd1, 5'd2, 5'd3, 1'b1, 3'b010, 4'b0000, 32'h40, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_wb_src", 32'(o_wb_src), 32'd0);
    check("rst_rd", 32'(o_rd_addr), 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);

    // ADD x3,x1,x2
    drive(OP_OP, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 4'b0000, 32'h100, 1'b1);
    tick();
    check("add_valid", 32'(o_valid), 32'd1);
    check("add_rd", 32'(o_rd_addr), 32'd3);
    check("add_alu", 32'(o_alu_ctrl), 32'd0);
    check("add_rs1_data", o_rs1_data, 32'h1100);
    check("add_funct3", 32'(o_funct3), 32'd2);
    #1 check("add_stall", 32'(o_stall), 32'd0);

    // LW x5 then dependent ADD x6,x5,x1
    drive(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 3'b001, 4'b0000, 32'h104, 1'b1);
    tick();
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h108, 1'b1);
    #1 check("lu_stall", 32'(o_stall), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(o_valid), 32'd0);
    check("lu_bubble_we", 32'(o_rf_we), 32'd0);
    check("lu_bubble_rd", 32'(o_rd_addr), 32'd0);
    #1 check("lu_no_refire", 32'(o_stall), 32'd0);
    tick();
    check("lu_add_valid", 32'(o_valid), 32'd1);
    check("lu_add_rs1", 32'(o_rs1_addr), 32'd5);
    check("lu_add_rd", 32'(o_rd_addr), 32'd6);

    // LW x0 never triggers a hazard
    drive(OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b1, 3'b001, 4'b0000, 32'h10c, 1'b1);
    tick();
    drive(OP_OP, 5'd0, 5'd0, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h110, 1'b1);
    #1 check("x0_stall", 32'(o_stall), 32'd0);
    tick();
    check("x0_add_valid", 32'(o_valid), 32'd1);
    check("x0_add_pc", o_pc, 32'h110);

    // Operand-use decode against LW x5 in EX
    drive(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 3'b001, 4'b0000, 32'h114, 1'b1);
    tick();
    drive(OP_LUI, 5'd5, 5'd5, 5'd5, 1'b1, 3'b011, 4'b0000, 32'h118, 1'b1);
    #1 check("lui_stall", 32'(o_stall), 32'd0);
    drive(OP_JAL, 5'd5, 5'd5, 5'd1, 1'b1, 3'b010, 4'b0000, 32'h118, 1'b1);
    #1 check("jal_stall", 32'(o_stall), 32'd0);
    drive(OP_STORE, 5'd1, 5'd5, 5'd0, 1'b0, 3'b000, 4'b0000, 32'h118, 1'b1);
    #1 check("sw_rs2_stall", 32'(o_stall), 32'd1);
    drive(OP_OPIMM, 5'd1, 5'd5, 5'd7, 1'b1, 3'b000, 4'b0000, 32'h118, 1'b1);
    #1 check("opimm_rs2_stall", 32'(o_stall), 32'd0);
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h118, 1'b0);
    #1 check("idinvalid_stall", 32'(o_stall), 32'd0);

    // Flush masks a pending load-use and loads a bubble
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h118, 1'b1);
    flush = 1'b1;
    #1 check("flush_stall", 32'(o_stall), 32'd0);
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_rd", 32'(o_rd_addr), 32'd0);

    // Hold freezes the registers
    drive(OP_OP, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 4'b0010, 32'h200, 1'b1);
    tick();
    hold = 1'b1;
    drive(OP_OP, 5'd4, 5'd4, 5'd9, 1'b1, 3'b000, 4'b0111, 32'h300, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("hold_rd", 32'(o_rd_addr), 32'd3);
      check("hold_pc", o_pc, 32'h200);
      check("hold_alu", 32'(o_alu_ctrl), 32'd2);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    hold = 1'b0;
    check("hold_flush_valid", 32'(o_valid), 32'd0);

    // Reset during a stall discards it
    drive(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 3'b001, 4'b0000, 32'h120, 1'b1);
    tick();
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h124, 1'b1);
    #1 check("pre_rst_stall", 32'(o_stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(o_stall), 32'd0);
    check("post_rst_valid", 32'(o_valid), 32'd0);

`ifdef ID_EX_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 3'b001, 4'b0000, 32'h130, 1'b1);
    tick();
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h134, 1'b1);
    tick();
    tick();
    drive(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 3'b001, 4'b0000, 32'h138, 1'b1);
    tick();
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h13c, 1'b1);
    tick();
    drive(OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 3'b001, 4'b0000, 32'h140, 1'b1);
    tick();
    drive(OP_OP, 5'd5, 5'd1, 5'd6, 1'b1, 3'b000, 4'b0000, 32'h144, 1'b1);
    hold = 1'b1;
    tick();
    hold = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("bubble_cnt", o_bubble_cnt, 32'd2);
    check("flush_cnt", o_flush_cnt, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("bubble_cnt_rst", o_bubble_cnt, 32'd0);
    check("flush_cnt_rst", o_flush_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX boundary of the pipelined RV32I core.
- Registers the decode-stage control bundle (the control unit's outputs) plus operands, immediates and register addresses, for one-cycle delivery to EX.
- Contains the load-use hazard detector: on a hazard it inserts a bubble and tells IF/ID and the PC to hold.
- Honours a flush from EX on a taken branch or jump, and a global hold from memory.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register-file address width.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_alu_op_src_ctrl, i_branch, i_jump, i_rf_we_ctrl, i_bu_jb_ctrl, i_mem_we  in  1 each  decode control.
- i_sx_imm_src_ctrl  in  3  immediate-type select.
- i_rf_wb_scr_ctrl  in  3  writeback source select.
- i_alu_ctrl  in  4  ALU operation.
- i_opcode  in  7  decode opcode; used for operand-use detection.
- i_funct3  in  3  forwarded to EX/MEM for branch type and load/store size.
- i_pc, i_pc_plus4, i_rs1_data, i_rs2_data, i_imm  in  XLEN each  decode data.
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  REG_ADDR_W each  register addresses.
- i_id_valid  in  1  decode slot holds a real instruction.
- i_flush  in  1  EX resolved a taken branch or jump.
- i_hold  in  1  global stall from memory.
- o_<each control input>  out  same widths  registered control.
- o_funct3, o_pc, o_pc_plus4, o_rs1_data, o_rs2_data, o_imm, o_rs1_addr, o_rs2_addr, o_rd_addr  out  same widths  registered data.
- o_valid  out  1  EX slot holds a real instruction.
- o_hazard_stall  out  1  combinational; IF/ID and PC must hold this cycle.

Behaviour:
- Reset (i_rst=1 at the edge): every registered output is 0, including o_valid.
  - o_rf_wb_scr_ctrl resets to 3'b000, not the decode default of 3'b010.
- Latency: exactly one cycle, ID to EX.
- rs1_used: opcode is not LUI, AUIPC or JAL.
- rs2_used: opcode is OP, STORE or BRANCH.
- load_use condition, all of the following true:
  - o_valid=1, o_rf_we_ctrl=1, o_rf_wb_scr_ctrl=WB_SRC_MEM (3'b001), o_rd_addr!=0.
  - i_id_valid=1.
  - (rs1_used and i_rs1_addr==o_rd_addr) or (rs2_used and i_rs2_addr==o_rd_addr).
- o_hazard_stall = load_use & ~i_flush & ~i_hold.
- Per-edge priority:
  1. i_rst: clear everything.
  2. i_flush: load a bubble. Flush overrides i_hold; a redirect is never lost.
  3. i_hold: all registers keep their value.
  4. load_use: load a bubble. The instruction in ID stays in IF/ID and re-enters next cycle.
  5. Otherwise: capture all inputs; o_valid <= i_id_valid.
- Bubble contents:
  - o_valid, o_rf_we_ctrl, o_mem_we, o_branch, o_jump, o_bu_jb_ctrl = 0.
  - All other fields = 0.
- i_id_valid=0 with no other event: captured as-is. Controls pass through and EX gates side effects with o_valid.
- Back-to-back load-use is impossible: after a bubble, o_valid=0, so the condition cannot re-fire.
- Flush and load_use in the same cycle: bubble is loaded; o_hazard_stall=0.
- Reset mid-stall: stall state is discarded; o_hazard_stall=0 in the cycle after reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds o_bubble_cnt (32) and o_flush_cnt (32).
  - Both reset to 0.
  - Each increments by 1 on an edge where a load_use bubble or a flush, respectively, is loaded.
  - Neither counts while i_hold is asserted, except flushes.
  - Both wrap at 2^32-1 to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- parameters.vh gains:
  - WB_SRC_ALU=3'b000, WB_SRC_MEM=3'b001, WB_SRC_PC4=3'b010, WB_SRC_IMM=3'b011, WB_SRC_AUIPC=3'b100.
  - Widths IMM_SRC_W=3, ALU_CTRL_W=4.
  - Existing OPCODE_* defines are reused.
- One sub-module: hazard_detect.
  - Combinational.
  - Inputs: opcode, rs1/rs2 addresses, i_id_valid, EX rd/we/wb-src/valid.
  - Output: load_use.
- The register bank stays in id_ex_stage.

Test Plan:
1. Reset, then ADD x3,x1,x2 (alu_ctrl 0000, rf_we 1) with i_id_valid=1 -> next cycle o_valid=1, o_rd_addr=3, o_alu_ctrl=0000, o_hazard_stall=0.
2. LW x5 in EX (wb 001, rf_we 1, valid) with ADD x6,x5,x1 in ID -> o_hazard_stall=1 that cycle; next cycle o_valid=0, o_rf_we_ctrl=0; then ADD captured with o_rs1_addr=5.
3. LW x0 in EX with ADD x6,x0,x0 in ID -> o_hazard_stall=0; ADD captured directly.
4. LW x5 in EX with LUI x5 in ID, then JAL in ID -> no stall in either case (rs1/rs2 unused).
5. Load-use pending plus i_flush=1 -> o_hazard_stall=0; bubble loaded. i_hold=1 alone for 3 cycles -> outputs frozen; bubble and flush counters unchanged with ID_EX_PERF_CNT_EN.
6. With ID_EX_PERF_CNT_EN: 2 load-use bubbles and 1 flush -> o_bubble_cnt=2, o_flush_cnt=1. Assert i_rst -> both 0 on the next cycle.
